// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - decode/writeback/ALU-side signal bundle for operand_fetch
interface operand_fetch_if #(
    parameter int AW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     rs_addr;
    logic [AW-1:0]     rt_addr;
    logic [AW-1:0]     rd_addr;
    logic signed [7:0] imm;
    logic              use_imm;
    logic              alu_ctrl_in;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic signed [7:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] input1;
    logic signed [7:0] input2;
    logic              alu_ctrl;
    logic [AW-1:0]     rd_out;

    modport master (
        output in_valid, rs_addr, rt_addr, rd_addr, imm, use_imm, alu_ctrl_in,
        output wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, input1, input2, alu_ctrl, rd_out
    );

    modport slave (
        input  in_valid, rs_addr, rt_addr, rd_addr, imm, use_imm, alu_ctrl_in,
        input  wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, input1, input2, alu_ctrl, rd_out
    );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file + operand fetch stage feeding the ALU
// Optional same-cycle writeback forwarding: define OPFETCH_FWD_EN.
module operand_fetch #(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             n_reset,
    operand_fetch_if.slave   bus
);

    logic signed [7:0] regs [NREG];
    logic signed [7:0] rs_val;
    logic signed [7:0] rt_val;
    logic signed [7:0] op_b;
    logic              wb_hit;
    logic              accept;

    // Register 0 is never written, so it stays at its reset value of zero.
    assign wb_hit = bus.wb_en && (bus.wb_addr != '0);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        rs_val = (bus.rs_addr == '0) ? 8'sd0 : regs[bus.rs_addr];
        rt_val = (bus.rt_addr == '0) ? 8'sd0 : regs[bus.rt_addr];
`ifdef OPFETCH_FWD_EN
        if (wb_hit && (bus.wb_addr == bus.rs_addr)) begin
            rs_val = bus.wb_data;
        end
        if (wb_hit && (bus.wb_addr == bus.rt_addr)) begin
            rt_val = bus.wb_data;
        end
`endif
        op_b = bus.use_imm ? bus.imm : rt_val;
    end

    // Single-entry output buffer: a draining entry can be replaced on the same edge.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bus.out_valid <= 1'b0;
            bus.input1    <= '0;
            bus.input2    <= '0;
            bus.alu_ctrl  <= 1'b0;
            bus.rd_out    <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.input1    <= rs_val;
            bus.input2    <= op_b;
            bus.alu_ctrl  <= bus.alu_ctrl_in;
            bus.rd_out    <= bus.rd_addr;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed table-driven bench for operand_fetch
module tb_operand_fetch;

`ifdef OPFETCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic       wb_en;
        logic [2:0] wb_addr;
        logic [7:0] wb_data;
        logic       iv;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [7:0] imm;
        logic       ui;
        logic       ctl;
        logic       ordy;
        logic       e_rdy;
        logic       e_v;
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic       e_c;
        logic [2:0] e_rd;
    } vec_t;

    localparam int NV = 19;

    logic clk;
    logic n_reset;
    int   checks;
    int   errors;
    vec_t vecs [NV];

    operand_fetch_if #(.AW(3)) bus ();

    operand_fetch #(.NREG(8)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic       wb_en, input logic [2:0] wb_addr, input logic [7:0] wb_data,
        input logic       iv, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
        input logic [7:0] imm, input logic ui, input logic ctl, input logic ordy,
        input logic       e_rdy, input logic e_v, input logic [7:0] e_a, input logic [7:0] e_b,
        input logic       e_c, input logic [2:0] e_rd);
        vec_t v;
        v.wb_en = wb_en; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.iv = iv; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.ui = ui;
        v.ctl = ctl; v.ordy = ordy; v.e_rdy = e_rdy; v.e_v = e_v;
        v.e_a = e_a; v.e_b = e_b; v.e_c = e_c; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [7:0] a,
                            input logic [7:0] b, input logic c, input logic [2:0] rd);
        chk({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, v});
        chk({tag, ".input1"}, bus.input1, a);
        chk({tag, ".input2"}, bus.input2, b);
        chk({tag, ".alu_ctrl"}, {7'd0, bus.alu_ctrl}, {7'd0, c});
        chk({tag, ".rd_out"}, {5'd0, bus.rd_out}, {5'd0, rd});
    endtask

    task automatic drive(input vec_t v);
        bus.wb_en = v.wb_en; bus.wb_addr = v.wb_addr; bus.wb_data = v.wb_data;
        bus.in_valid = v.iv; bus.rs_addr = v.rs; bus.rt_addr = v.rt; bus.rd_addr = v.rd;
        bus.imm = v.imm; bus.use_imm = v.ui; bus.alu_ctrl_in = v.ctl; bus.out_ready = v.ordy;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_reset = 1'b0;
        drive(mk(0,0,0, 0,0,0,0, 0,0,0,1, 0,0,0,0,0,0));

        //         wb_en addr data   iv rs rt rd imm    ui ctl ordy | rdy v  in1    in2    c  rd
        vecs[0]  = mk(1, 3, 8'h40, 0, 0, 0, 0, 8'h00, 0, 0, 1,   1, 0, 8'h00, 8'h00, 0, 0);
        vecs[1]  = mk(1, 5, 8'hC0, 0, 0, 0, 0, 8'h00, 0, 0, 1,   1, 0, 8'h00, 8'h00, 0, 0);
        vecs[2]  = mk(0, 0, 8'h00, 1, 3, 5, 1, 8'h00, 0, 0, 1,   1, 1, 8'h40, 8'hC0, 0, 1);
        vecs[3]  = mk(0, 0, 8'h00, 1, 3, 5, 2, 8'h7F, 1, 1, 1,   1, 1, 8'h40, 8'h7F, 1, 2);
        vecs[4]  = mk(1, 0, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0, 1,   1, 0, 8'h40, 8'h7F, 1, 2);
        vecs[5]  = mk(0, 0, 8'h00, 1, 0, 3, 7, 8'h00, 0, 0, 1,   1, 1, 8'h00, 8'h40, 0, 7);
        vecs[6]  = mk(1, 2, 8'h11, 1, 2, 2, 3, 8'h00, 0, 1, 1,   1, 1,
                      FWD ? 8'h11 : 8'h00, FWD ? 8'h11 : 8'h00, 1, 3);
        vecs[7]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1,   1, 0,
                      FWD ? 8'h11 : 8'h00, FWD ? 8'h11 : 8'h00, 1, 3);
        vecs[8]  = mk(1, 4, 8'h10, 0, 0, 0, 0, 8'h00, 0, 0, 1,   1, 0,
                      FWD ? 8'h11 : 8'h00, FWD ? 8'h11 : 8'h00, 1, 3);
        vecs[9]  = mk(0, 0, 8'h00, 1, 4, 0, 4, 8'h05, 1, 0, 1,   1, 1, 8'h10, 8'h05, 0, 4);
        // stall three cycles while r4 is rewritten underneath the held entry
        vecs[10] = mk(1, 4, 8'h20, 1, 3, 5, 6, 8'h00, 0, 1, 0,   0, 1, 8'h10, 8'h05, 0, 4);
        vecs[11] = mk(0, 0, 8'h00, 1, 3, 5, 6, 8'h00, 0, 1, 0,   0, 1, 8'h10, 8'h05, 0, 4);
        vecs[12] = mk(0, 0, 8'h00, 1, 3, 5, 6, 8'h00, 0, 1, 0,   0, 1, 8'h10, 8'h05, 0, 4);
        vecs[13] = mk(0, 0, 8'h00, 1, 3, 5, 6, 8'h00, 0, 1, 1,   1, 1, 8'h40, 8'hC0, 1, 6);
        vecs[14] = mk(0, 0, 8'h00, 1, 4, 4, 5, 8'h00, 0, 0, 1,   1, 1, 8'h20, 8'h20, 0, 5);
        vecs[15] = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1,   1, 0, 8'h20, 8'h20, 0, 5);
        // writeback to r0 must never forward
        vecs[16] = mk(1, 0, 8'h33, 1, 0, 0, 1, 8'h00, 0, 1, 1,   1, 1, 8'h00, 8'h00, 1, 1);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 1,   1, 0, 8'h00, 8'h00, 1, 1);
        vecs[18] = mk(0, 0, 8'h00, 1, 2, 5, 2, 8'h00, 0, 0, 1,   1, 1, 8'h11, 8'hC0, 0, 2);

        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 8'h00, 8'h00, 0, 0);
        chk("reset.in_ready", {7'd0, bus.in_ready}, 8'h01);
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.in_ready", i), {7'd0, bus.in_ready}, {7'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            chk_outs($sformatf("v%0d", i), vecs[i].e_v, vecs[i].e_a, vecs[i].e_b,
                     vecs[i].e_c, vecs[i].e_rd);
        end

        // Reset asserted asynchronously while an entry is held in a stall.
        @(negedge clk);
        drive(mk(0,0,0, 1,3,5,6, 0,0,1,0, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk("stall_pre_reset.out_valid", {7'd0, bus.out_valid}, 8'h01);
        chk("stall_pre_reset.input1", bus.input1, 8'h11);
        #2;
        n_reset = 1'b0;
        #1;
        chk_outs("async_reset", 0, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        n_reset = 1'b1;
        drive(mk(0,0,0, 1,3,5,7, 0,0,1,1, 0,0,0,0,0,0));
        @(posedge clk);
        #1;
        chk_outs("post_reset_read", 1, 8'h00, 8'h00, 1, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
